// File: rtl/trigger_ts_pkg.sv
// Shared defaults and helpers for the trigger timestamping path.
// Widths here are defaults only; instances override them through parameters.
package trigger_ts_pkg;

  localparam int unsigned TS_WIDTH_DEF       = 48;
  localparam int unsigned SEQ_WIDTH_DEF      = 16;
  localparam int unsigned FIFO_DEPTH_DEF     = 16;
  localparam int unsigned DROP_CNT_WIDTH_DEF = 16;
  localparam int unsigned ENTRY_WIDTH_DEF    = TS_WIDTH_DEF + SEQ_WIDTH_DEF;

  function automatic int unsigned clog2(input int unsigned value);
    int unsigned result;
    result = 0;
    while ((32'd1 << result) < value) result++;
    return result;
  endfunction

endpackage

// File: rtl/sync_fifo_fwft.sv
// First-word-fall-through synchronous FIFO with async reset and sync flush.
// A push while full is accepted only when a pop frees a slot in the same cycle.
module sync_fifo_fwft
  import trigger_ts_pkg::*;
#(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 flush,
  input  logic                 push,
  input  logic [WIDTH-1:0]     din,
  output logic                 full,
  input  logic                 pop,
  output logic [WIDTH-1:0]     dout,
  output logic                 empty,
  output logic [clog2(DEPTH):0] level
);

  localparam int unsigned AW = clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count;
  logic             do_push;
  logic             do_pop;

  assign empty   = (count == '0);
  assign full    = (count == (AW+1)'(DEPTH));
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  // Empty reads as zero so the data output is clean after reset or flush.
  assign dout    = empty ? '0 : mem[rd_ptr];
  assign level   = count;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push && !flush) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/trigger_timestamper.sv
// Tags rising trigger edges with a cycle timestamp and sequence number and
// streams them out over AXI4-Stream, tracking overflow and dropped events.
module trigger_timestamper
  import trigger_ts_pkg::*;
#(
  parameter int unsigned TS_WIDTH       = TS_WIDTH_DEF,
  parameter int unsigned SEQ_WIDTH      = SEQ_WIDTH_DEF,
  parameter int unsigned FIFO_DEPTH     = FIFO_DEPTH_DEF,
  parameter int unsigned DROP_CNT_WIDTH = DROP_CNT_WIDTH_DEF
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        run,
  input  logic                        trigger,
  output logic [TS_WIDTH-1:0]         m_axis_tdata,
  output logic [SEQ_WIDTH-1:0]        m_axis_tuser,
  output logic                        m_axis_tvalid,
  input  logic                        m_axis_tready,
  output logic                        overflow,
  output logic [DROP_CNT_WIDTH-1:0]   drop_count,
  output logic [clog2(FIFO_DEPTH):0]  fifo_level
);

  localparam int unsigned ENTRY_W = TS_WIDTH + SEQ_WIDTH;

  logic [TS_WIDTH-1:0]  ts;
  logic [SEQ_WIDTH-1:0] seq;
  logic                 trig_d;
  logic                 run_d;
  logic                 run_rise;
  logic                 trig_event;
  logic                 pop_fire;
  logic                 drop;
  logic                 fifo_full;
  logic                 fifo_empty;
  logic [ENTRY_W-1:0]   fifo_din;
  logic [ENTRY_W-1:0]   fifo_dout;

  assign run_rise      = run & ~run_d;
  assign trig_event    = trigger & ~trig_d & run & ~run_rise;
  assign m_axis_tvalid = ~fifo_empty;
  assign pop_fire      = m_axis_tvalid & m_axis_tready;
  // A full FIFO still takes the event when the head leaves in the same cycle.
  assign drop          = trig_event & fifo_full & ~pop_fire;
  assign fifo_din      = {ts, seq};
  assign {m_axis_tdata, m_axis_tuser} = fifo_dout;

  sync_fifo_fwft #(
    .WIDTH (ENTRY_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (reset),
    .flush (run_rise),
    .push  (trig_event),
    .din   (fifo_din),
    .full  (fifo_full),
    .pop   (pop_fire),
    .dout  (fifo_dout),
    .empty (fifo_empty),
    .level (fifo_level)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ts         <= '0;
      seq        <= '0;
      trig_d     <= 1'b0;
      run_d      <= 1'b0;
      overflow   <= 1'b0;
      drop_count <= '0;
    end else begin
      trig_d <= trigger;
      run_d  <= run;
      if (run_rise) begin
        ts         <= '0;
        seq        <= '0;
        overflow   <= 1'b0;
        drop_count <= '0;
      end else begin
        if (run)        ts  <= ts + TS_WIDTH'(1);
        if (trig_event) seq <= seq + SEQ_WIDTH'(1);
        if (drop) begin
          overflow <= 1'b1;
          if (drop_count != '1) drop_count <= drop_count + DROP_CNT_WIDTH'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_trigger_timestamper.sv
// Directed and randomized checks of trigger_timestamper against a queue-based
// event model; a narrow second instance exposes timestamp wrap and drop saturation.
module tb_trigger_timestamper;

  localparam int unsigned TSW   = 32;
  localparam int unsigned SQW   = 8;
  localparam int unsigned DEPTH = 4;
  localparam int unsigned DCW   = 16;

  logic clk = 1'b0;
  logic reset, run, trigger, tready;

  logic [TSW-1:0] tdata;
  logic [SQW-1:0] tuser;
  logic           tvalid, overflow;
  logic [DCW-1:0] drop_count;
  logic [2:0]     level;

  logic [3:0]     s_tdata;
  logic [SQW-1:0] s_tuser;
  logic           s_tvalid, s_overflow;
  logic [1:0]     s_drop;
  logic [2:0]     s_level;

  trigger_timestamper #(
    .TS_WIDTH(TSW), .SEQ_WIDTH(SQW), .FIFO_DEPTH(DEPTH), .DROP_CNT_WIDTH(DCW)
  ) dut (
    .clk(clk), .reset(reset), .run(run), .trigger(trigger),
    .m_axis_tdata(tdata), .m_axis_tuser(tuser), .m_axis_tvalid(tvalid),
    .m_axis_tready(tready), .overflow(overflow), .drop_count(drop_count),
    .fifo_level(level)
  );

  trigger_timestamper #(
    .TS_WIDTH(4), .SEQ_WIDTH(SQW), .FIFO_DEPTH(DEPTH), .DROP_CNT_WIDTH(2)
  ) dut_small (
    .clk(clk), .reset(reset), .run(run), .trigger(trigger),
    .m_axis_tdata(s_tdata), .m_axis_tuser(s_tuser), .m_axis_tvalid(s_tvalid),
    .m_axis_tready(tready), .overflow(s_overflow), .drop_count(s_drop),
    .fifo_level(s_level)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] ts;
    logic [7:0]  seq;
  } ev_t;

  ev_t         q[$];
  logic [31:0] m_ts;
  logic [7:0]  m_seq;
  bit          m_run_d, m_trig_d, m_ovf;
  int unsigned m_drops;
  int          compared = 0;
  int          mismatched = 0;
  bit          run_state;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    chk("tvalid", 64'(tvalid), 64'(q.size() != 0));
    chk("s_tvalid", 64'(s_tvalid), 64'(q.size() != 0));
    if (q.size() != 0) begin
      chk("tdata", 64'(tdata), 64'(q[0].ts));
      chk("tuser", 64'(tuser), 64'(q[0].seq));
      chk("s_tdata", 64'(s_tdata), 64'(q[0].ts[3:0]));
      chk("s_tuser", 64'(s_tuser), 64'(q[0].seq));
    end
    chk("level", 64'(level), 64'(q.size()));
    chk("s_level", 64'(s_level), 64'(q.size()));
    chk("overflow", 64'(overflow), 64'(m_ovf));
    chk("s_overflow", 64'(s_overflow), 64'(m_ovf));
    chk("drop_count", 64'(drop_count), 64'((m_drops > 65535) ? 65535 : m_drops));
    chk("s_drop", 64'(s_drop), 64'((m_drops > 3) ? 3 : m_drops));
  endtask

  // Reference behaviour for one clock edge given the inputs seen before it.
  task automatic model_step(input bit r, input bit t, input bit rdy, input bit rst);
    bit rise, ev, pop, was_full;
    if (rst) begin
      q.delete();
      m_ts = 0; m_seq = 0; m_run_d = 0; m_trig_d = 0; m_ovf = 0; m_drops = 0;
      return;
    end
    rise     = r && !m_run_d;
    ev       = t && !m_trig_d && r && !rise;
    pop      = (q.size() != 0) && rdy;
    was_full = (q.size() == DEPTH);
    if (rise) begin
      q.delete();
      m_ts = 0; m_seq = 0; m_ovf = 0; m_drops = 0;
    end else begin
      if (pop) void'(q.pop_front());
      if (ev) begin
        if (!was_full || pop) q.push_back({m_ts, m_seq});
        else begin
          m_ovf = 1;
          m_drops++;
        end
        m_seq++;
      end
      if (r) m_ts++;
    end
    m_run_d  = r;
    m_trig_d = t;
  endtask

  task automatic step(input bit r, input bit t, input bit rdy);
    run = r; trigger = t; tready = rdy;
    check_all();
    model_step(r, t, rdy, reset);
    @(posedge clk);
    #1;
  endtask

  task automatic expect_beat(input string tag, input logic [31:0] ts, input logic [7:0] seq);
    chk({tag, "_tvalid"}, 64'(tvalid), 64'(1));
    chk({tag, "_ts"}, 64'(tdata), 64'(ts));
    chk({tag, "_seq"}, 64'(tuser), 64'(seq));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset = 1'b1; run = 1'b0; trigger = 1'b0; tready = 1'b1;
    model_step(0, 0, 1, 1);
    repeat (2) @(posedge clk);
    #1;
    chk("rst_tvalid", 64'(tvalid), 64'(0));
    chk("rst_tdata", 64'(tdata), 64'(0));
    chk("rst_tuser", 64'(tuser), 64'(0));
    chk("rst_level", 64'(level), 64'(0));
    chk("rst_overflow", 64'(overflow), 64'(0));
    chk("rst_drop", 64'(drop_count), 64'(0));
    reset = 1'b0;
    step(0, 0, 1);
    step(0, 0, 1);

    // Two spaced triggers after a run rising edge
    step(1, 0, 1);
    for (int c = 1; c <= 9; c++) step(1, 0, 1);
    step(1, 1, 1);
    expect_beat("A_ev0", 9, 0);
    step(1, 0, 1);
    chk("A_popped", 64'(tvalid), 64'(0));
    for (int c = 12; c <= 19; c++) step(1, 0, 1);
    step(1, 1, 1);
    expect_beat("A_ev1", 19, 1);
    step(1, 0, 1);

    // Level-high trigger gives one event; edges with run low are ignored
    step(0, 0, 1); step(0, 0, 1);
    step(1, 0, 1);
    for (int c = 1; c <= 9; c++) step(1, 0, 1);
    step(1, 1, 1);
    expect_beat("B_ev", 9, 0);
    for (int c = 11; c <= 15; c++) step(1, 1, 1);
    chk("B_single_level", 64'(level), 64'(0));
    step(1, 0, 1); step(1, 0, 1);
    step(0, 0, 1); step(0, 1, 1); step(0, 0, 1);
    chk("B_run0_tvalid", 64'(tvalid), 64'(0));

    // Overflow with tready low, then drain
    step(1, 0, 0);
    for (int k = 1; k <= 34; k++) step(1, (k % 5 == 0) && (k <= 30), 0);
    chk("C_level", 64'(level), 64'(4));
    chk("C_overflow", 64'(overflow), 64'(1));
    chk("C_drop", 64'(drop_count), 64'(2));
    for (int i = 0; i < 4; i++) begin
      expect_beat("C_drain", 32'(4 + 5 * i), 8'(i));
      step(1, 0, 1);
    end
    step(1, 1, 1);
    expect_beat("C_next", 38, 6);
    step(1, 0, 1);

    // Full FIFO with a pop in the trigger cycle accepts the event
    for (int k = 1; k <= 8; k++) step(1, (k % 2) == 1, 0);
    chk("D_full_level", 64'(level), 64'(4));
    step(1, 1, 1);
    chk("D_level_kept", 64'(level), 64'(4));
    chk("D_drop_same", 64'(drop_count), 64'(2));
    for (int i = 0; i < 4; i++) begin
      chk("D_drain_seq", 64'(tuser), 64'(8 + i));
      step(1, 0, 1);
    end

    // Timestamp wrap on the narrow instance, sequence wrap, drop saturation
    step(0, 0, 1);
    step(1, 0, 1);
    for (int c = 1; c <= 14; c++) step(1, 0, 1);
    step(1, 1, 1);
    chk("E_ts_pre_wrap", 64'(s_tdata), 64'(4'hE));
    chk("E_ts_full", 64'(tdata), 64'(14));
    step(1, 0, 1); step(1, 0, 1);
    step(1, 1, 1);
    chk("E_ts_wrapped", 64'(s_tdata), 64'(4'h1));
    chk("E_ts_full2", 64'(tdata), 64'(17));
    step(1, 0, 1);
    for (int i = 0; i < 254; i++) begin
      step(1, 1, 1);
      step(1, 0, 1);
    end
    step(1, 1, 1);
    chk("E_seq_wrap", 64'(tuser), 64'(0));
    step(1, 0, 1);
    step(1, 0, 0);
    for (int k = 0; k < 20; k++) step(1, (k % 2) == 0, 0);
    chk("E_drop6", 64'(drop_count), 64'(6));
    chk("E_drop_sat", 64'(s_drop), 64'(3));

    // Randomized traffic
    run_state = 1'b1;
    for (int n = 0; n < 1500; n++) begin
      if ($urandom_range(199) == 0) run_state = ~run_state;
      step(run_state, $urandom_range(2) == 0, $urandom_range(1) == 1);
    end

    // Asynchronous reset with events buffered
    step(0, 0, 0);
    step(1, 0, 0);
    for (int k = 1; k <= 30; k++) step(1, (k % 5) == 0, 0);
    chk("G_pre_valid", 64'(tvalid), 64'(1));
    chk("G_pre_overflow", 64'(overflow), 64'(1));
    #2 reset = 1'b1;
    #1;
    chk("G_async_tvalid", 64'(tvalid), 64'(0));
    chk("G_async_level", 64'(level), 64'(0));
    chk("G_async_overflow", 64'(overflow), 64'(0));
    chk("G_async_drop", 64'(drop_count), 64'(0));
    model_step(0, 0, 1, 1);
    step(0, 0, 1); step(0, 0, 1);
    reset = 1'b0;
    step(0, 0, 1);
    step(1, 0, 1);
    for (int c = 1; c <= 9; c++) step(1, 0, 1);
    step(1, 1, 1);
    expect_beat("G_restart", 9, 0);
    step(1, 0, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/trigger_timestamper.md
Name: trigger_timestamper

Overview:
- Sits directly downstream of the frame trigger generator. Consumes its `trigger` output on the same clock.
- Detects each rising edge of `trigger` and tags it with a free-running cycle timestamp and a sequence number.
- Buffers the tagged events in a small FIFO and presents them on an AXI4-Stream master, so the DMA/packetiser can align photon data to frame boundaries.
- Reports overflow and dropped-event count for software status.

Parameters:
- TS_WIDTH, 48, width of timestamp counter and of m_axis_tdata.
- SEQ_WIDTH, 16, width of event sequence number (m_axis_tuser).
- FIFO_DEPTH, 16, event FIFO entries; power of two, minimum 2.
- DROP_CNT_WIDTH, 16, width of the dropped-event counter.

Ports:
- clk  in  1  Single clock for all logic.
- reset  in  1  Asynchronous, active-high reset.
- run  in  1  Acquisition run qualifier (same `run` as the trigger generator).
- trigger  in  1  Trigger pulse from the trigger generator, synchronous to clk.
- m_axis_tdata  out  TS_WIDTH  Timestamp of the event.
- m_axis_tuser  out  SEQ_WIDTH  Sequence number of the event.
- m_axis_tvalid  out  1  Event available.
- m_axis_tready  in  1  Downstream accepts the event.
- overflow  out  1  Sticky: at least one event dropped since the run started.
- drop_count  out  DROP_CNT_WIDTH  Number of dropped events, saturating.
- fifo_level  out  $clog2(FIFO_DEPTH)+1  Current FIFO occupancy.

Behaviour:
- Reset (async assert, sync release): all of the following clear to 0.
  - ts counter, seq counter, trig_d, run_d.
  - FIFO pointers.
  - Outputs m_axis_tvalid, m_axis_tdata, m_axis_tuser, overflow, drop_count, fifo_level.
  - Reset mid-stream discards buffered events. tvalid drops in the same cycle.
- run rising edge (run=1, run_d=0) acts as a synchronous clear:
  - ts counter, seq, FIFO pointers, overflow and drop_count all go to 0.
  - An output beat that is valid in that cycle is discarded, even if tready=1.
- Timestamp counter:
  - Increments by 1 every cycle while run=1, starting from 0 in the cycle after the run rising edge.
  - Holds while run=0.
  - Wraps modulo 2^TS_WIDTH with no flag.
- Edge detect:
  - trig_d registers trigger every cycle, regardless of run.
  - An event fires when trigger=1, trig_d=0 and run=1 (and it is not the run-rising cycle).
  - Level-high trigger yields exactly one event.
  - Edges while run=0 are ignored.
- Capture:
  - The event carries the ts counter value present in the same cycle the edge is sampled, and the current seq.
  - seq increments after every event, including dropped ones, so software sees gaps. seq wraps modulo 2^SEQ_WIDTH.
- FIFO (first-word-fall-through):
  - An event is written at the clock edge where it is detected.
  - m_axis_tvalid rises in the next cycle; latency from trigger edge to tvalid is 1 cycle.
  - Pop occurs on tvalid & tready.
  - tdata/tuser are stable while tvalid=1 and tready=0 (AXIS rule).
- Full boundary:
  - Event with FIFO full and no pop in the same cycle: the event is dropped, overflow is set, and drop_count increments, saturating at all-ones.
  - Event with FIFO full and a pop in the same cycle: the event is accepted and the level stays at FIFO_DEPTH.
- Empty boundary: simultaneous push and pop while empty is impossible, because tvalid=0. The push is accepted, and the level becomes 1.
- fifo_level is registered and reflects the occupancy after each clock edge.

Decomposition:
- Package trigger_ts_pkg holds:
  - Default widths TS_WIDTH, SEQ_WIDTH, DROP_CNT_WIDTH, FIFO_DEPTH.
  - Constant for the FIFO entry width (TS_WIDTH+SEQ_WIDTH).
  - Function clog2 for the level width.
- Sub-module sync_fifo_fwft:
  - Parameterised width and depth, with asynchronous active-high reset plus a synchronous flush.
  - Ports: push/din/full, pop/dout/empty, level.
  - Reusable for other event buffers in the design.
- The top level contains the counters, edge detect and drop logic.

Test Plan (TS_WIDTH=32, SEQ_WIDTH=8, FIFO_DEPTH=4, tready=1 unless stated):
- run rises at cycle 0; trigger rising at cycles 10, 20 → events {ts=9,seq=0} and {ts=19,seq=1}; each tvalid appears 1 cycle after its edge.
- trigger held high for cycles 10–15 → exactly one event {ts=9,seq=0}; edge while run=0 → no event, seq unchanged.
- tready=0; 6 triggers spaced 5 cycles apart → fifo_level=4, events 4–5 dropped, overflow=1, drop_count=2. Then tready=1 → outputs seq 0,1,2,3; the next event has seq=6.
- FIFO full with tready=1 in the cycle a trigger edge occurs → event accepted, level stays 4, drop_count unchanged.
- Preload ts to 0xFFFFFFFE via long run, then trigger 3 cycles apart → ts wraps (0xFFFFFFFE, then 0x00000001), no flag; seq wraps 255→0 after 256 events.
- Assert reset with 3 events buffered and tvalid=1 → tvalid=0 immediately (asynchronous), level=0, overflow=0, drop_count=0; after release, the next run starts at ts=0, seq=0.
